// File: rtl/wbu_pkg.sv
// Shared configuration for the writeback stage: default widths,
// writeback-source codes and load-format (funct3) encodings.
package wbu_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int GPRS_WIDTH_DEF = 5;
  localparam int ARGS_WIDTH     = 2;

  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_ALU = 2'd0;
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_MEM = 2'd1;
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_PC  = 2'd2;

  localparam logic [2:0] FMT_LB  = 3'd0;
  localparam logic [2:0] FMT_LH  = 3'd1;
  localparam logic [2:0] FMT_LW  = 3'd2;
  localparam logic [2:0] FMT_LD  = 3'd3;
  localparam logic [2:0] FMT_LBU = 3'd4;
  localparam logic [2:0] FMT_LHU = 3'd5;
  localparam logic [2:0] FMT_LWU = 3'd6;

endpackage

// File: rtl/wbu_fmt.sv
// Combinational load extractor and writeback source mux.
module wbu_fmt
  import wbu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [ARGS_WIDTH-1:0]           i_src,
  input  logic [2:0]                      i_fmt,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] i_off,
  input  logic [ADDR_WIDTH-1:0]           i_pc,
  input  logic [DATA_WIDTH-1:0]           i_alu,
  input  logic [DATA_WIDTH-1:0]           i_ram,
  output logic [DATA_WIDTH-1:0]           o_data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    shifted = i_ram >> {i_off, 3'b000};
    load    = '0;
    case (i_fmt)
      FMT_LB:  load = DATA_WIDTH'($signed(shifted[7:0]));
      FMT_LH:  load = DATA_WIDTH'($signed(shifted[15:0]));
      FMT_LW:  load = DATA_WIDTH'($signed(shifted[31:0]));
      FMT_LBU: load = DATA_WIDTH'(shifted[7:0]);
      FMT_LHU: load = DATA_WIDTH'(shifted[15:0]);
      // Doubleword and unsigned-word loads only exist on a 64-bit datapath.
      FMT_LD:  if (DATA_WIDTH == 64) load = shifted;
      FMT_LWU: if (DATA_WIDTH == 64) load = DATA_WIDTH'(shifted[31:0]);
      default: load = '0;
    endcase

    o_data = '0;
    case (i_src)
      REG_WR_SRC_ALU: o_data = i_alu;
      REG_WR_SRC_MEM: o_data = load;
      REG_WR_SRC_PC:  o_data = DATA_WIDTH'(i_pc);
      default:        o_data = '0;
    endcase
  end

endmodule

// File: rtl/wbu_pipe.sv
// Writeback stage: head/skid entry pair behind a registered-ready handshake,
// gated GPR commit, forwarding port and retire counter.
module wbu_pipe
  import wbu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int GPRS_WIDTH = GPRS_WIDTH_DEF,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_sys_valid,
  output logic                            o_sys_ready,
  input  logic                            i_reg_wr_en,
  input  logic [ARGS_WIDTH-1:0]           i_reg_wr_src,
  input  logic [2:0]                      i_ram_fmt,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] i_ram_off,
  input  logic [ADDR_WIDTH-1:0]           i_ifu_pc,
  input  logic [DATA_WIDTH-1:0]           i_alu_res,
  input  logic [DATA_WIDTH-1:0]           i_ram_res,
  input  logic [GPRS_WIDTH-1:0]           i_gpr_wr_id,
  input  logic                            i_commit_ready,
  output logic                            o_gpr_wr_en,
  output logic [GPRS_WIDTH-1:0]           o_gpr_wr_id,
  output logic [DATA_WIDTH-1:0]           o_gpr_wr_data,
  output logic                            o_fwd_valid,
  output logic [GPRS_WIDTH-1:0]           o_fwd_id,
  output logic [DATA_WIDTH-1:0]           o_fwd_data,
  output logic [CNT_WIDTH-1:0]            o_retire_cnt
);

  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic [GPRS_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                head_q, head_d, skid_q, skid_d, in_entry;
  logic                  sys_ready_q, sys_ready_d;
  logic [CNT_WIDTH-1:0]  retire_cnt_q, retire_cnt_d;
  logic [DATA_WIDTH-1:0] fmt_data;
  logic                  accept, commit, head_writes;

  wbu_fmt #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fmt (
    .i_src  (i_reg_wr_src),
    .i_fmt  (i_ram_fmt),
    .i_off  (i_ram_off),
    .i_pc   (i_ifu_pc),
    .i_alu  (i_alu_res),
    .i_ram  (i_ram_res),
    .o_data (fmt_data)
  );

  always_comb begin
    accept   = i_sys_valid && sys_ready_q;
    commit   = head_q.valid && i_commit_ready;
    in_entry = '{valid: 1'b1, wr_en: i_reg_wr_en, id: i_gpr_wr_id, data: fmt_data};

    head_d       = head_q;
    skid_d       = skid_q;
    retire_cnt_d = retire_cnt_q;

    if (commit) begin
      retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
      head_d       = skid_q;
      skid_d       = '0;
    end
    // After any commit/promote, a new entry lands in head if it is free, else in skid.
    if (accept) begin
      if (!head_d.valid) head_d = in_entry;
      else               skid_d = in_entry;
    end

    sys_ready_d = !skid_d.valid;
  end

  // NOTE: reset is synchronous and sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q       <= '0;
      skid_q       <= '0;
      sys_ready_q  <= 1'b1;
      retire_cnt_q <= '0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      sys_ready_q  <= sys_ready_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_comb begin
    head_writes   = head_q.valid && head_q.wr_en && (head_q.id != '0);
    o_sys_ready   = sys_ready_q;
    o_retire_cnt  = retire_cnt_q;
    o_gpr_wr_en   = head_writes && i_commit_ready;
    o_gpr_wr_id   = o_gpr_wr_en ? head_q.id   : '0;
    o_gpr_wr_data = o_gpr_wr_en ? head_q.data : '0;
    o_fwd_valid   = head_writes;
    o_fwd_id      = head_writes ? head_q.id   : '0;
    o_fwd_data    = head_writes ? head_q.data : '0;
  end

endmodule

// File: tb/tb_wbu_pipe.sv
// Self-checking bench for wbu_pipe: directed vectors, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_wbu_pipe;
  import wbu_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sys_valid = 1'b0;
  logic        reg_wr_en = 1'b0;
  logic [1:0]  reg_wr_src = '0;
  logic [2:0]  ram_fmt = '0;
  logic [2:0]  ram_off = '0;
  logic [31:0] ifu_pc = '0;
  logic [63:0] alu_res = '0;
  logic [63:0] ram_res = '0;
  logic [4:0]  wr_id_in = '0;
  logic        commit_ready = 1'b0;

  logic        sys_ready, gpr_wr_en, fwd_valid;
  logic [4:0]  gpr_wr_id, fwd_id;
  logic [63:0] gpr_wr_data, fwd_data, retire_cnt;

  wbu_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GPRS_WIDTH(5), .CNT_WIDTH(64)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sys_valid    (sys_valid),
    .o_sys_ready    (sys_ready),
    .i_reg_wr_en    (reg_wr_en),
    .i_reg_wr_src   (reg_wr_src),
    .i_ram_fmt      (ram_fmt),
    .i_ram_off      (ram_off),
    .i_ifu_pc       (ifu_pc),
    .i_alu_res      (alu_res),
    .i_ram_res      (ram_res),
    .i_gpr_wr_id    (wr_id_in),
    .i_commit_ready (commit_ready),
    .o_gpr_wr_en    (gpr_wr_en),
    .o_gpr_wr_id    (gpr_wr_id),
    .o_gpr_wr_data  (gpr_wr_data),
    .o_fwd_valid    (fwd_valid),
    .o_fwd_id       (fwd_id),
    .o_fwd_data     (fwd_data),
    .o_retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        wr_en;
    logic [4:0]  id;
    logic [63:0] data;
  } ent_t;

  ent_t        q[$];
  logic [63:0] cnt_m;
  logic        ready_m;

  typedef struct {
    logic [1:0]  src;
    logic [2:0]  fmt;
    logic [2:0]  off;
    logic [31:0] pc;
    logic [63:0] alu;
    logic [63:0] ram;
    logic [4:0]  id;
    logic        wr_en;
    logic [63:0] exp_data;
    logic        exp_wr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load formatter: shift, mask to the access width, then extend.
  function automatic logic [63:0] ref_load(input int fmt, input int off, input logic [63:0] ram);
    logic [63:0] s, mask, v;
    int nbits;
    bit sgn;
    s = ram >> (8 * off);
    case (fmt)
      0: begin nbits = 8;  sgn = 1; end
      1: begin nbits = 16; sgn = 1; end
      2: begin nbits = 32; sgn = 1; end
      3: begin nbits = 64; sgn = 1; end
      4: begin nbits = 8;  sgn = 0; end
      5: begin nbits = 16; sgn = 0; end
      6: begin nbits = 32; sgn = 0; end
      default: return 64'd0;
    endcase
    if (nbits == 64) return s;
    mask = (64'd1 << nbits) - 64'd1;
    v = s & mask;
    if (sgn && s[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [63:0] ref_data(input int src, input int fmt, input int off,
                                           input logic [31:0] pc, input logic [63:0] alu,
                                           input logic [63:0] ram);
    case (src)
      0: return alu;
      1: return ref_load(fmt, off, ram);
      2: return {32'd0, pc};
      default: return 64'd0;
    endcase
  endfunction

  task automatic set_in(input logic v, input logic [1:0] src, input logic [2:0] fmt,
                        input logic [2:0] off, input logic [31:0] pc, input logic [63:0] alu,
                        input logic [63:0] ram, input logic [4:0] id, input logic we,
                        input logic cr);
    sys_valid    = v;
    reg_wr_src   = src;
    ram_fmt      = fmt;
    ram_off      = off;
    ifu_pc       = pc;
    alu_res      = alu;
    ram_res      = ram;
    wr_id_in     = id;
    reg_wr_en    = we;
    commit_ready = cr;
  endtask

  // Compare every output against the model, advance the model across one edge.
  task automatic step();
    ent_t h;
    logic hv, exp_wr, exp_fv;
    #1;
    hv     = q.size() > 0;
    h      = hv ? q[0] : '0;
    exp_fv = hv && h.wr_en && (h.id != 5'd0);
    exp_wr = exp_fv && commit_ready;
    check("ready",     64'(sys_ready),   64'(ready_m));
    check("wr_en",     64'(gpr_wr_en),   64'(exp_wr));
    check("wr_id",     64'(gpr_wr_id),   exp_wr ? 64'(h.id) : 64'd0);
    check("wr_data",   gpr_wr_data,      exp_wr ? h.data : 64'd0);
    check("fwd_valid", 64'(fwd_valid),   64'(exp_fv));
    check("fwd_id",    64'(fwd_id),      exp_fv ? 64'(h.id) : 64'd0);
    check("fwd_data",  fwd_data,         exp_fv ? h.data : 64'd0);
    check("retire",    retire_cnt,       cnt_m);
    if (rst) begin
      q.delete();
      cnt_m   = 64'd0;
      ready_m = 1'b1;
    end else begin
      if (hv && commit_ready) begin
        void'(q.pop_front());
        cnt_m = cnt_m + 64'd1;
      end
      if (sys_valid && ready_m)
        q.push_back('{wr_en: reg_wr_en, id: wr_id_in,
                      data: ref_data(int'(reg_wr_src), int'(ram_fmt), int'(ram_off),
                                     ifu_pc, alu_res, ram_res)});
      ready_m = q.size() < 2;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{REG_WR_SRC_MEM, FMT_LB,  3'd1, 32'd0, 64'd0, 64'h80FF, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
    vecs[1]  = '{REG_WR_SRC_MEM, FMT_LBU, 3'd1, 32'd0, 64'd0, 64'h80FF, 5'd3, 1'b1, 64'h80, 1'b1};
    vecs[2]  = '{REG_WR_SRC_MEM, FMT_LH,  3'd2, 32'd0, 64'd0, 64'h8001_0000, 5'd4, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b1};
    vecs[3]  = '{REG_WR_SRC_PC,  FMT_LB,  3'd0, 32'h8000_0004, 64'd0, 64'd0, 5'd5, 1'b1, 64'h0000_0000_8000_0004, 1'b1};
    vecs[4]  = '{REG_WR_SRC_MEM, FMT_LD,  3'd0, 32'd0, 64'd0, 64'hFFFF_FFFF_0000_0001, 5'd6, 1'b1, 64'hFFFF_FFFF_0000_0001, 1'b1};
    vecs[5]  = '{REG_WR_SRC_MEM, FMT_LW,  3'd4, 32'd0, 64'd0, 64'h8765_4321_0000_0000, 5'd7, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b1};
    vecs[6]  = '{REG_WR_SRC_MEM, FMT_LWU, 3'd4, 32'd0, 64'd0, 64'h8765_4321_0000_0000, 5'd8, 1'b1, 64'h8765_4321, 1'b1};
    vecs[7]  = '{REG_WR_SRC_MEM, FMT_LHU, 3'd6, 32'd0, 64'd0, 64'hFFEE_0000_0000_0000, 5'd9, 1'b1, 64'hFFEE, 1'b1};
    vecs[8]  = '{REG_WR_SRC_ALU, FMT_LB,  3'd0, 32'd0, 64'h1234_5678_9ABC_DEF0, 64'd0, 5'd10, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1};
    vecs[9]  = '{2'd3,           FMT_LB,  3'd0, 32'h44, 64'h77, 64'h99, 5'd11, 1'b1, 64'd0, 1'b1};
    vecs[10] = '{REG_WR_SRC_ALU, FMT_LB,  3'd0, 32'd0, 64'h55, 64'd0, 5'd0, 1'b1, 64'd0, 1'b0};
    vecs[11] = '{REG_WR_SRC_ALU, FMT_LB,  3'd0, 32'd0, 64'h66, 64'd0, 5'd12, 1'b0, 64'd0, 1'b0};
    vecs[12] = '{REG_WR_SRC_MEM, FMT_LB,  3'd7, 32'd0, 64'd0, 64'h7F00_0000_0000_0000, 5'd13, 1'b1, 64'h7F, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   64'(sys_ready), 64'd1);
    check("rst_wr_en",   64'(gpr_wr_en), 64'd0);
    check("rst_fwd",     64'(fwd_valid), 64'd0);
    check("rst_wr_data", gpr_wr_data,    64'd0);
    check("rst_retire",  retire_cnt,     64'd0);
    q.delete();
    cnt_m   = 64'd0;
    ready_m = 1'b1;
    rst     = 1'b0;

    // Streaming ALU writes to x1..x4, one commit per cycle
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b1, REG_WR_SRC_ALU, 3'd0, 3'd0, 32'd0, 64'h100 + 64'(k), 64'd0, 5'(k), 1'b1, 1'b1);
      if (k > 1) begin
        #1;
        check("stream_wr_en", 64'(gpr_wr_en), 64'd1);
        check("stream_wr_id", 64'(gpr_wr_id), 64'(k - 1));
      end
      step();
    end
    set_in(1'b0, REG_WR_SRC_ALU, 3'd0, 3'd0, 32'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
    #1;
    check("stream_wr_id4", 64'(gpr_wr_id), 64'd4);
    step();
    check("stream_retire", retire_cnt, 64'd4);

    // Stall with valid held: two entries held, ready drops, then in-order drain
    set_in(1'b1, REG_WR_SRC_ALU, 3'd0, 3'd0, 32'd0, 64'hAAAA, 64'd0, 5'd7, 1'b1, 1'b0);
    step();
    check("stall_ready1", 64'(sys_ready), 64'd1);
    check("stall_fwd_id", 64'(fwd_id),    64'd7);
    set_in(1'b1, REG_WR_SRC_ALU, 3'd0, 3'd0, 32'd0, 64'hBBBB, 64'd0, 5'd8, 1'b1, 1'b0);
    step();
    check("stall_ready2", 64'(sys_ready), 64'd0);
    step();
    check("stall_hold_data", fwd_data, 64'hAAAA);
    check("stall_no_write",  64'(gpr_wr_en), 64'd0);
    step();
    set_in(1'b0, REG_WR_SRC_ALU, 3'd0, 3'd0, 32'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
    #1;
    check("drain1_id",   64'(gpr_wr_id), 64'd7);
    check("drain1_data", gpr_wr_data,    64'hAAAA);
    step();
    check("drain2_id",    64'(gpr_wr_id), 64'd8);
    check("drain2_data",  gpr_wr_data,    64'hBBBB);
    check("drain_ready",  64'(sys_ready), 64'd1);
    step();

    // Reset with both entries full
    set_in(1'b1, REG_WR_SRC_ALU, 3'd0, 3'd0, 32'd0, 64'hCCCC, 64'd0, 5'd9, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_in(1'b0, REG_WR_SRC_ALU, 3'd0, 3'd0, 32'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
    #1;
    check("rstfull_ready",  64'(sys_ready), 64'd1);
    check("rstfull_wr_en",  64'(gpr_wr_en), 64'd0);
    check("rstfull_fwd",    64'(fwd_valid), 64'd0);
    check("rstfull_retire", retire_cnt,     64'd0);
    step();

    // Directed formatting / source / x0 vectors
    for (int i = 0; i < 13; i++) begin
      set_in(1'b1, vecs[i].src, vecs[i].fmt, vecs[i].off, vecs[i].pc, vecs[i].alu,
             vecs[i].ram, vecs[i].id, vecs[i].wr_en, 1'b1);
      step();
      set_in(1'b0, REG_WR_SRC_ALU, 3'd0, 3'd0, 32'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
      #1;
      check($sformatf("vec%0d_wr_en", i), 64'(gpr_wr_en), 64'(vecs[i].exp_wr));
      check($sformatf("vec%0d_data", i),  gpr_wr_data,    vecs[i].exp_wr ? vecs[i].exp_data : 64'd0);
      step();
    end
    check("vec_retire", retire_cnt, 64'd13);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 6)),
             3'($urandom_range(0, 7)), $urandom, {$urandom, $urandom}, {$urandom, $urandom},
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
      step();
    end
    rst = 1'b0;
    set_in(1'b0, REG_WR_SRC_ALU, 3'd0, 3'd0, 32'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b1);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
